// File: rtl/gate_unit_arbiter.sv
// Arbitrates NREQ requesters onto one shared combinational gate unit: grant, execute, respond.
// Define GATE_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module gate_unit_arbiter #(
   parameter  int unsigned NREQ = 4,
   parameter  int unsigned W    = 8,
   localparam int unsigned IDW  = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [3*NREQ-1:0] op,
   input  logic [W*NREQ-1:0] opa,
   input  logic [W*NREQ-1:0] opb,
   output logic [NREQ-1:0]   gnt,
   output logic              rsp_valid,
   output logic [IDW-1:0]    rsp_id,
   output logic [W-1:0]      rsp_data,
   output logic              rsp_err,
   output logic              busy,
   output logic [W-1:0]      gu_a,
   output logic [W-1:0]      gu_b,
   output logic [2:0]        gu_sel,
   input  logic [W-1:0]      gu_y
);

   localparam int unsigned SW = 3;
   localparam int unsigned CW = IDW + 1;
   localparam logic [SW-1:0] OP_RSVD = 3'd7;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   gnt_d;
   logic              rsp_valid_d, rsp_err_d, busy_d;
   logic [IDW-1:0]    rsp_id_d, id_q, id_d;
   logic [W-1:0]      rsp_data_d, gu_a_d, gu_b_d;
   logic [SW-1:0]     gu_sel_d;

   logic              win_vld;
   logic [IDW-1:0]    win_id;
   logic [SW-1:0]     win_op;
   logic [W-1:0]      win_a, win_b;

`ifdef GATE_ARB_RR_EN
   logic [IDW-1:0]    ptr_q, ptr_d;

   // Round-robin search starting at ptr_q, wrapping at NREQ.
   always_comb begin
      logic [CW-1:0] cand;
      win_vld = 1'b0;
      win_id  = '0;
      cand    = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         cand = {1'b0, ptr_q} + CW'(i);
         if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
         if (!win_vld && req[cand[IDW-1:0]]) begin
            win_vld = 1'b1;
            win_id  = cand[IDW-1:0];
         end
      end
   end
`else
   // Fixed priority: lowest requesting index wins.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!win_vld && req[IDW'(i)]) begin
            win_vld = 1'b1;
            win_id  = IDW'(i);
         end
      end
   end
`endif

   // Operand mux for the winning requester.
   always_comb begin
      win_op = '0;
      win_a  = '0;
      win_b  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (win_id == IDW'(i)) begin
            win_op = op[SW*i +: SW];
            win_a  = opa[W*i +: W];
            win_b  = opb[W*i +: W];
         end
      end
   end

   // Next-state and next-output logic; gu_* double as the operand latch.
   always_comb begin
      state_d     = state_q;
      id_d        = id_q;
      gnt_d       = '0;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id;
      rsp_data_d  = rsp_data;
      rsp_err_d   = rsp_err;
      busy_d      = 1'b0;
      gu_a_d      = '0;
      gu_b_d      = '0;
      gu_sel_d    = '0;
`ifdef GATE_ARB_RR_EN
      ptr_d       = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d  = EXEC;
               id_d     = win_id;
               gnt_d    = NREQ'(1) << win_id;
               gu_a_d   = win_a;
               gu_b_d   = win_b;
               gu_sel_d = win_op;
               busy_d   = 1'b1;
`ifdef GATE_ARB_RR_EN
               ptr_d    = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
`endif
            end
         end
         EXEC: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            rsp_err_d   = (gu_sel == OP_RSVD);
            rsp_data_d  = rsp_err_d ? '0 : gu_y;
            busy_d      = 1'b1;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         id_q      <= '0;
         gnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
         busy      <= 1'b0;
         gu_a      <= '0;
         gu_b      <= '0;
         gu_sel    <= '0;
`ifdef GATE_ARB_RR_EN
         ptr_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         id_q      <= id_d;
         gnt       <= gnt_d;
         rsp_valid <= rsp_valid_d;
         rsp_id    <= rsp_id_d;
         rsp_data  <= rsp_data_d;
         rsp_err   <= rsp_err_d;
         busy      <= busy_d;
         gu_a      <= gu_a_d;
         gu_b      <= gu_b_d;
         gu_sel    <= gu_sel_d;
`ifdef GATE_ARB_RR_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Scoreboard bench for gate_unit_arbiter; models the shared gate unit and checks grants/responses.
module tb_gate_unit_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned W    = 8;
   localparam int unsigned IDW  = 2;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [W-1:0]   data;
      logic           err;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req;
   logic [3*NREQ-1:0] op;
   logic [W*NREQ-1:0] opa, opb;
   logic [NREQ-1:0]   gnt;
   logic              rsp_valid, rsp_err, busy;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_data, gu_a, gu_b, gu_y;
   logic [2:0]        gu_sel;

   exp_t sb_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   gate_unit_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .op(op), .opa(opa), .opb(opb),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .busy(busy), .gu_a(gu_a), .gu_b(gu_b), .gu_sel(gu_sel),
      .gu_y(gu_y)
   );

   always #5 clk = ~clk;

   // Shared gate unit; reserved select returns junk so the arbiter must mask it.
   function automatic logic [W-1:0] gate_fn(input logic [2:0] s, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      case (s)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return ~a;
         3'd3: return ~(a | b);
         3'd4: return ~(a & b);
         3'd5: return a ^ b;
         3'd6: return ~(a ^ b);
         default: return 8'hA5;
      endcase
   endfunction

   always_comb gu_y = gate_fn(gu_sel, gu_a, gu_b);

   // Response monitor: pops the scoreboard on each rsp_valid.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
         vectors++;
         if (sb_q.size() == 0) begin
            miscompares++;
            $display("FAIL rsp_unexpected: got id=%0d data=%h err=%b, expected no response",
                     rsp_id, rsp_data, rsp_err);
         end else begin
            e = sb_q.pop_front();
            if ({rsp_id, rsp_data, rsp_err} !== e) begin
               miscompares++;
               $display("FAIL rsp_payload: got id=%0d data=%h err=%b, expected id=%0d data=%h err=%b",
                        rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic apply_reset();
      rst_n = 1'b0;
      req   = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req = '0; op = '0; opa = '0; opb = '0;
      repeat (2) @(posedge clk); #1;
      vectors++;
      if ({gnt, rsp_valid, rsp_id, rsp_data, rsp_err, busy, gu_a, gu_b, gu_sel} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: got gnt=%b busy=%b rsp_valid=%b gu_sel=%0d, expected all 0",
                  gnt, busy, rsp_valid, gu_sel);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      req[1] = 1'b1; op[5:3] = 3'd5; opa[15:8] = 8'h3C; opb[15:8] = 8'h0F;
      @(posedge clk); #1;
      vectors++;
      if (gnt !== 4'b0010 || busy !== 1'b1 || gu_sel !== 3'd5) begin
         miscompares++;
         $display("FAIL reset_pre_exec: got gnt=%b busy=%b gu_sel=%0d, expected 0010 1 5",
                  gnt, busy, gu_sel);
      end
      req   = '0;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({gnt, rsp_valid, rsp_id, rsp_data, rsp_err, busy, gu_a, gu_b, gu_sel} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_exec: got gnt=%b busy=%b gu_a=%h gu_sel=%0d, expected all 0",
                  gnt, busy, gu_a, gu_sel);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk); #1;
      vectors++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_after_release: got busy=%b rsp_valid=%b, expected 0 0", busy, rsp_valid);
      end
   endtask

   // One isolated transaction; new_a is written to the winner's opa during EXEC.
   task automatic do_op(input int id, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_d,
                        input logic [W-1:0] new_a, input string name);
      int waited = 0;
      op[3*id +: 3] = o; opa[W*id +: W] = a; opb[W*id +: W] = b;
      req[id] = 1'b1;
      sb_q.push_back('{id: IDW'(id), data: exp_d, err: (o == 3'd7)});
      do begin
         @(posedge clk); #1;
         waited++;
      end while (gnt == '0 && waited < 20);
      vectors++;
      if (gnt !== (NREQ'(1) << id) || waited !== 1) begin
         miscompares++;
         $display("FAIL %s_gnt: got gnt=%b after %0d cycles, expected %b after 1",
                  name, gnt, waited, NREQ'(1) << id);
      end
      vectors++;
      if (gu_sel !== o || gu_a !== a || gu_b !== b || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_exec: got sel=%0d a=%h b=%h busy=%b, expected sel=%0d a=%h b=%h busy=1",
                  name, gu_sel, gu_a, gu_b, busy, o, a, b);
      end
      req[id] = 1'b0;
      opa[W*id +: W] = new_a;
      @(posedge clk); #1;
      vectors++;
      if (rsp_valid !== 1'b1 || gnt !== '0 || gu_sel !== 3'd0 || gu_a !== '0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_resp: got rsp_valid=%b gnt=%b gu_sel=%0d gu_a=%h busy=%b, expected 1 0 0 00 1",
                  name, rsp_valid, gnt, gu_sel, gu_a, busy);
      end
      @(posedge clk); #1;
      vectors++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_idle: got rsp_valid=%b busy=%b, expected 0 0", name, rsp_valid, busy);
      end
   endtask

   task automatic test_op_sweep();
      logic [W-1:0] tbl [7] = '{8'hC0, 8'hFC, 8'h0F, 8'h03, 8'h3F, 8'h3C, 8'hC3};
      for (int i = 0; i < 7; i++)
         do_op(0, 3'(i), 8'hF0, 8'hCC, tbl[i], 8'hF0, "sweep");
   endtask

   task automatic test_reserved();
      do_op(0, 3'd7, 8'hF0, 8'hCC, 8'h00, 8'hF0, "reserved");
   endtask

   task automatic test_operand_latch();
      do_op(3, 3'd0, 8'hAA, 8'hFF, 8'hAA, 8'h55, "latch");
      do_op(2, 3'd5, 8'h96, 8'h0F, 8'h99, 8'h00, "latch_id2");
   endtask

   task automatic test_back_to_back();
      int cyc = 0, last = 0, n = 0;
      logic [W-1:0] av [4] = '{8'h12, 8'hE7, 8'h5A, 8'h81};
      logic [W-1:0] bv [4] = '{8'h34, 8'h3C, 8'hF0, 8'h18};
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         op[3*i +: 3] = 3'(i + 3); opa[W*i +: W] = av[i]; opb[W*i +: W] = bv[i];
         sb_q.push_back('{id: IDW'(i), data: gate_fn(3'(i + 3), av[i], bv[i]), err: 1'b0});
      end
      req = 4'b1111;
      while (n < 4 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (gnt != '0) begin
            vectors++;
            if (gnt !== (NREQ'(1) << n) || (n > 0 && cyc - last != 3)) begin
               miscompares++;
               $display("FAIL b2b_grant%0d: got gnt=%b spacing=%0d, expected %b spacing=3",
                        n, gnt, cyc - last, NREQ'(1) << n);
            end
            req  = req & ~gnt;
            last = cyc;
            n++;
         end
      end
      vectors++;
      if (n !== 4) begin
         miscompares++;
         $display("FAIL b2b_timeout: got %0d grants, expected 4", n);
      end
      repeat (3) @(posedge clk); #1;
   endtask

   task automatic test_priority();
      int exp_id [4];
`ifdef GATE_ARB_RR_EN
      exp_id = '{0, 2, 0, 2};
`else
      exp_id = '{0, 0, 0, 0};
`endif
      apply_reset();
      op[2:0] = 3'd5; opa[7:0]   = 8'h12; opb[7:0]   = 8'h34;
      op[8:6] = 3'd1; opa[23:16] = 8'h0F; opb[23:16] = 8'h30;
      for (int r = 0; r < 4; r++)
         sb_q.push_back('{id: IDW'(exp_id[r]),
                          data: (exp_id[r] == 0) ? 8'h26 : 8'h3F, err: 1'b0});
      req = 4'b0101;
      for (int r = 0; r < 4; r++) begin
         int waited = 0;
         do begin
            @(posedge clk); #1;
            waited++;
         end while (gnt == '0 && waited < 10);
         vectors++;
         if (gnt !== (NREQ'(1) << exp_id[r])) begin
            miscompares++;
            $display("FAIL prio_round%0d: got gnt=%b, expected %b", r, gnt, NREQ'(1) << exp_id[r]);
         end
         if (r == 3) req = '0;
      end
      repeat (3) @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_op_sweep();
      test_reserved();
      test_operand_latch();
      test_back_to_back();
      test_priority();
      repeat (3) @(posedge clk); #1;
      vectors++;
      if (sb_q.size() !== 0) begin
         miscompares++;
         $display("FAIL sb_drain: got %0d pending responses, expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
